// File: rtl/tour_cmd.sv
// -----------------------------------------------------------------------------
// tour_cmd
//   Turns the solved knight's-tour move list into motion commands.
//   Each L-shaped move becomes two commands: a vertical leg (OPC_MOVE), then a
//   horizontal leg (OPC_FANFARE). Both are handed to the command processor with
//   a cmd_rdy / clr_cmd_rdy handshake and a send_resp completion. When no tour
//   is running, the UART command path passes straight through.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start_tour      pulse that starts playback of a solved tour
//   move[7:0]       one-hot move from the solver, read at mv_indx
//   mv_indx[4:0]    index of the move currently being issued
//   cmd_UART[15:0]  UART command, forwarded while idle
//   cmd_rdy_UART    UART command valid, forwarded while idle
//   cmd[15:0]       {opcode[3:0], heading[7:0], squares[3:0]}
//   cmd_rdy         cmd valid
//   clr_cmd_rdy     command processor has taken cmd
//   send_resp       command processor has finished cmd
//   resp[7:0]       8'hA5 idle/done, 8'h5A tour leg acknowledged
// -----------------------------------------------------------------------------
module tour_cmd #(
    parameter int          LAST_INDX   = 23,
    parameter logic [3:0]  OPC_MOVE    = 4'h2,
    parameter logic [3:0]  OPC_FANFARE = 4'h3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp
);

    localparam logic [4:0] LAST    = 5'(LAST_INDX);
    localparam logic [7:0] H_NORTH = 8'h00;
    localparam logic [7:0] H_WEST  = 8'h3F;
    localparam logic [7:0] H_SOUTH = 8'h7F;
    localparam logic [7:0] H_EAST  = 8'hBF;
    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_ACK  = 8'h5A;

    typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} state_t;

    state_t     r_state;
    logic [4:0] r_mv_indx;

    logic [7:0] w_v_head, w_h_head;
    logic [3:0] w_v_sq,   w_h_sq;

    // Sequencing: only the state the block is waiting in reacts to
    // clr_cmd_rdy / send_resp; anything else is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_mv_indx <= '0;
        end else begin
            case (r_state)
                IDLE: if (start_tour) begin
                    r_state   <= VERT;
                    r_mv_indx <= '0;
                end
                VERT:   if (clr_cmd_rdy) r_state <= WAIT_V;
                WAIT_V: if (send_resp)   r_state <= HORZ;
                HORZ:   if (clr_cmd_rdy) r_state <= WAIT_H;
                WAIT_H: if (send_resp) begin
                    if (r_mv_indx == LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_state   <= VERT;
                        r_mv_indx <= r_mv_indx + 5'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Move decode. Lowest set bit wins; an empty move decodes to two
    // zero-length northward legs so playback still advances.
    always_comb begin
        w_v_head = H_NORTH; w_v_sq = 4'd0;
        w_h_head = H_NORTH; w_h_sq = 4'd0;
        if (move[0]) begin        // (+1,+2)
            w_v_head = H_NORTH; w_v_sq = 4'd2; w_h_head = H_EAST; w_h_sq = 4'd1;
        end else if (move[1]) begin // (-1,+2)
            w_v_head = H_NORTH; w_v_sq = 4'd2; w_h_head = H_WEST; w_h_sq = 4'd1;
        end else if (move[2]) begin // (-2,+1)
            w_v_head = H_NORTH; w_v_sq = 4'd1; w_h_head = H_WEST; w_h_sq = 4'd2;
        end else if (move[3]) begin // (-2,-1)
            w_v_head = H_SOUTH; w_v_sq = 4'd1; w_h_head = H_WEST; w_h_sq = 4'd2;
        end else if (move[4]) begin // (-1,-2)
            w_v_head = H_SOUTH; w_v_sq = 4'd2; w_h_head = H_WEST; w_h_sq = 4'd1;
        end else if (move[5]) begin // (+1,-2)
            w_v_head = H_SOUTH; w_v_sq = 4'd2; w_h_head = H_EAST; w_h_sq = 4'd1;
        end else if (move[6]) begin // (+2,-1)
            w_v_head = H_SOUTH; w_v_sq = 4'd1; w_h_head = H_EAST; w_h_sq = 4'd2;
        end else if (move[7]) begin // (+2,+1)
            w_v_head = H_NORTH; w_v_sq = 4'd1; w_h_head = H_EAST; w_h_sq = 4'd2;
        end
    end

    // Outputs are decoded from the state register. The move itself is not
    // latched: the solver holds it steady while mv_indx is unchanged, and the
    // idle pass-through has to be combinational anyway.
    always_comb begin
        cmd     = cmd_UART;
        cmd_rdy = cmd_rdy_UART;
        resp    = RESP_DONE;
        case (r_state)
            VERT: begin
                cmd = {OPC_MOVE, w_v_head, w_v_sq}; cmd_rdy = 1'b1; resp = RESP_ACK;
            end
            WAIT_V: begin
                cmd = {OPC_MOVE, w_v_head, w_v_sq}; cmd_rdy = 1'b0; resp = RESP_ACK;
            end
            HORZ: begin
                cmd = {OPC_FANFARE, w_h_head, w_h_sq}; cmd_rdy = 1'b1; resp = RESP_ACK;
            end
            WAIT_H: begin
                cmd     = {OPC_FANFARE, w_h_head, w_h_sq};
                cmd_rdy = 1'b0;
                // The final leg reports tour completion instead of an ack.
                resp    = (r_mv_indx == LAST) ? RESP_DONE : RESP_ACK;
            end
            default: ;
        endcase
    end

    assign mv_indx = r_mv_indx;

endmodule

// File: doc/tour_cmd.md
Name: tour_cmd

Overview:
- Downstream consumer of the knight's-tour solver.
- After the solver asserts done and the tour is started, it walks the solved move list by driving the move index and reading back each one-hot move.
- Splits every L-shaped move into two motion commands, a vertical leg then a horizontal leg, and hands them to the command processor with a ready/clear handshake.
- When no tour is running, it is a transparent mux that forwards UART-originated commands.

Parameters:
LAST_INDX, 23, index of the final move in the tour (a 5x5 board gives 24 moves).
OPC_MOVE, 4'h2, opcode for the vertical leg.
OPC_FANFARE, 4'h3, opcode for the horizontal leg (move with fanfare).

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous assert, active-low
start_tour  in  1  one-cycle pulse that begins command playback of a solved tour
move  in  8  one-hot move read combinationally from the solver at mv_indx
mv_indx  out  5  index of the move currently being issued
cmd_UART  in  16  command from the UART wrapper
cmd_rdy_UART  in  1  UART command valid
cmd  out  16  command to the command processor: [15:12] opcode, [11:4] heading, [3:0] squares
cmd_rdy  out  1  cmd valid
clr_cmd_rdy  in  1  command processor has accepted cmd
send_resp  in  1  command processor finished executing the current command
resp  out  8  response byte to UART: 8'hA5 = done or idle, 8'h5A = tour leg acknowledged

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE, mv_indx = 0.
  - Outputs settle to the IDLE mux values: cmd = cmd_UART, cmd_rdy = cmd_rdy_UART, resp = 8'hA5.
  - Reset mid-tour abandons the tour immediately; no partial command is reissued.
- States: IDLE, VERT, WAIT_V, HORZ, WAIT_H.
- IDLE:
  - Pass-through mux as above.
  - start_tour -> VERT, mv_indx <= 0.
- VERT:
  - cmd = {OPC_MOVE, vertical heading, |dy|}, cmd_rdy = 1.
  - clr_cmd_rdy -> WAIT_V.
- WAIT_V:
  - cmd_rdy = 0; cmd holds the vertical value.
  - send_resp -> HORZ.
- HORZ:
  - cmd = {OPC_FANFARE, horizontal heading, |dx|}, cmd_rdy = 1.
  - clr_cmd_rdy -> WAIT_H.
- WAIT_H, on send_resp:
  - mv_indx == LAST_INDX -> IDLE.
  - Otherwise mv_indx <= mv_indx + 1 -> VERT.
- Headings: north 8'h00, west 8'h3F, south 8'h7F, east 8'hBF.
- Move decode (dx, dy):
  - bit0 (+1,+2), bit1 (-1,+2), bit2 (-2,+1), bit3 (-2,-1)
  - bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1)
  - dy > 0 -> north, dy < 0 -> south; dx > 0 -> east, dx < 0 -> west.
- Decode edge cases:
  - Multiple bits set: lowest set bit wins.
  - move == 0: both legs issued as heading north, 0 squares; playback still advances.
- Move timing:
  - mv_indx changes on the same edge that enters VERT.
  - move is combinational from the solver, so it is valid throughout VERT..WAIT_H.
  - move is not latched.
- resp:
  - 8'h5A while in a tour state, except 8'hA5 when mv_indx == LAST_INDX and state is WAIT_H.
  - 8'hA5 in IDLE.
- While a tour is in progress:
  - start_tour is ignored.
  - cmd_rdy_UART and cmd_UART are ignored, not forwarded, and not cleared by this block.
- clr_cmd_rdy or send_resp arriving in a state that does not wait for it: ignored.
- clr_cmd_rdy and send_resp in the same cycle while in VERT: go to WAIT_V only; send_resp is not remembered.
- mv_indx wraps only by returning to IDLE; it never counts past LAST_INDX.

Test Plan:
- Reset, then cmd_UART = 16'h2BF3 with cmd_rdy_UART = 1 -> cmd = 16'h2BF3, cmd_rdy = 1, mv_indx = 0, resp = 8'hA5.
- start_tour with move = 8'h01 -> VERT shows cmd = 16'h2002, cmd_rdy = 1; after clr_cmd_rdy, cmd_rdy = 0; after send_resp, HORZ shows cmd = 16'h3BF1.
- move = 8'h08 -> vertical leg 16'h27F1, horizontal leg 16'h33F2; move = 8'h40 -> 16'h27F1 then 16'h3BF2.
- Full playback with a handshake model (clr_cmd_rdy 2 cycles after cmd_rdy, send_resp 10 cycles later):
  - Exactly 48 commands issued; mv_indx steps 0..23.
  - resp = 8'h5A until the last leg, then 8'hA5; block returns to IDLE.
- Pulse cmd_rdy_UART and start_tour again mid-tour -> no forwarding; mv_indx sequence unaffected.
- Assert rst_n = 0 in WAIT_H at mv_indx = 7 -> immediately mv_indx = 0, IDLE, cmd = cmd_UART.
